// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared types and constants for the Hack elementary-logic blocks.
//   word_t       : 16-bit Hack word
//   chan_sel_t   : 2-bit channel index (0=a, 1=b, 2=c, 3=d)
//   out_state_t  : occupancy of a one-entry output register
//   NUM_CHAN     : number of source channels on the 4-way collector
// -----------------------------------------------------------------------------
package hack_pkg;

  localparam int NUM_CHAN = 4;

  typedef logic [15:0] word_t;
  typedef logic [1:0]  chan_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage : hack_pkg

// File: rtl/rr_grant_4.sv
// -----------------------------------------------------------------------------
// rr_grant_4
// Combinational 4-way round-robin grant. Searches valid[] starting at ptr and
// wrapping modulo 4; the first asserted request wins.
// Ports:
//   valid  in   one bit per channel, request present
//   ptr    in   channel with highest priority this cycle
//   grant  out  one-hot grant (all zero when no request)
//   idx    out  encoded index of the granted channel (0 when no request)
// -----------------------------------------------------------------------------
module rr_grant_4
  import hack_pkg::*;
(
  input  logic [NUM_CHAN-1:0] valid,
  input  chan_sel_t           ptr,
  output logic [NUM_CHAN-1:0] grant,
  output chan_sel_t           idx
);

  logic      found;
  chan_sel_t cand;

  // NOTE: every variable written here gets a default first so no path through
  // the block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      // 2-bit addition wraps naturally, giving the modulo-4 search order.
      cand = ptr + chan_sel_t'(k);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule : rr_grant_4

// File: rtl/mux_4x1_rr.sv
// -----------------------------------------------------------------------------
// mux_4x1_rr
// Four-channel round-robin collector. Merges words from four valid/ready
// sources into one registered valid/ready output, one word at a time.
// Ports:
//   clk_in                 clock, rising edge
//   rst_in                 asynchronous reset, active-high
//   a_in..d_in             source data, channels 0..3
//   a_valid_in..d_valid_in source word present
//   a_ready_out..d_ready_out source word accepted this cycle (combinational,
//                          at most one high)
//   y_out                  registered output word
//   y_valid_out            y_out holds an unconsumed word
//   y_ready_in             sink accepts y_out this cycle
//   sel_out                channel index of the word in y_out
// -----------------------------------------------------------------------------
module mux_4x1_rr
  import hack_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] c_in,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  a_valid_in,
  input  logic                  b_valid_in,
  input  logic                  c_valid_in,
  input  logic                  d_valid_in,
  output logic                  a_ready_out,
  output logic                  b_ready_out,
  output logic                  c_ready_out,
  output logic                  d_ready_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_valid_out,
  input  logic                  y_ready_in,
  output chan_sel_t             sel_out
);

  logic [NUM_CHAN-1:0]   valid;
  logic [NUM_CHAN-1:0]   grant;
  logic [NUM_CHAN-1:0]   ready;
  logic [DATA_WIDTH-1:0] data [NUM_CHAN];
  chan_sel_t             grant_idx;
  chan_sel_t             ptr;
  logic                  load_en;
  logic                  in_xfer;
  logic                  out_xfer;
  out_state_t            state;
  out_state_t            state_next;

  assign valid   = {d_valid_in, c_valid_in, b_valid_in, a_valid_in};
  assign data[0] = a_in;
  assign data[1] = b_in;
  assign data[2] = c_in;
  assign data[3] = d_in;

  rr_grant_4 u_grant (
    .valid (valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // The register can accept when empty or when its word leaves this cycle;
  // that lets a new word replace a draining one with no bubble.
  assign load_en  = (state == EMPTY) | y_ready_in;
  assign ready    = grant & {NUM_CHAN{load_en}};
  assign {d_ready_out, c_ready_out, b_ready_out, a_ready_out} = ready;

  assign in_xfer     = |ready;
  assign y_valid_out = (state == FULL);
  assign out_xfer    = y_valid_out & y_ready_in;

  always_comb begin
    state_next = state;
    if (in_xfer) begin
      state_next = FULL;
    end else if (out_xfer) begin
      state_next = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the data register is reset too, because y_out=0 after reset is
  // externally visible behaviour, not just a don't-care.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y_out   <= '0;
      sel_out <= '0;
      ptr     <= '0;
    end else if (in_xfer) begin
      y_out   <= data[grant_idx];
      sel_out <= grant_idx;
      // Priority moves to the channel after the winner; wraps 3 -> 0.
      ptr     <= grant_idx + 2'd1;
    end
  end

endmodule : mux_4x1_rr

// File: tb/tb_mux_4x1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_4x1_rr
// Directed self-checking bench for mux_4x1_rr.
// -----------------------------------------------------------------------------
module tb_mux_4x1_rr;
  import hack_pkg::*;

  logic        clk_in;
  logic        rst_in;
  word_t       a_in, b_in, c_in, d_in;
  logic        a_valid_in, b_valid_in, c_valid_in, d_valid_in;
  logic        a_ready_out, b_ready_out, c_ready_out, d_ready_out;
  word_t       y_out;
  logic        y_valid_out;
  logic        y_ready_in;
  chan_sel_t   sel_out;

  int checks = 0;
  int errors = 0;

  mux_4x1_rr #(.DATA_WIDTH(16)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_in        (c_in),
    .d_in        (d_in),
    .a_valid_in  (a_valid_in),
    .b_valid_in  (b_valid_in),
    .c_valid_in  (c_valid_in),
    .d_valid_in  (d_valid_in),
    .a_ready_out (a_ready_out),
    .b_ready_out (b_ready_out),
    .c_ready_out (c_ready_out),
    .d_ready_out (d_ready_out),
    .y_out       (y_out),
    .y_valid_out (y_valid_out),
    .y_ready_in  (y_ready_in),
    .sel_out     (sel_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_valid(input logic [3:0] v);
    {d_valid_in, c_valid_in, b_valid_in, a_valid_in} = v;
  endtask

  function automatic logic [3:0] readys();
    return {d_ready_out, c_ready_out, b_ready_out, a_ready_out};
  endfunction

  task automatic check_out(input string tag, input logic v, input word_t y, input chan_sel_t s);
    check({tag, "_valid"}, 16'(v), 16'(y_valid_out));
    check({tag, "_y"}, y_out, y);
    check({tag, "_sel"}, 16'(sel_out), 16'(s));
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    set_valid(4'b0000);
    y_ready_in = 1'b0;
    #3;
    check_out("reset", 1'b0, 16'h0000, 2'd0);
    check("reset_ready_idle", 16'(readys()), 16'h0);
    tick();
    rst_in = 1'b0;

    // ---- Reset mid-stream while FULL ----
    a_in = 16'h1234;
    set_valid(4'b0001);
    #1;
    check("rst_a_ready", 16'(readys()), 16'b0001);
    tick();                               // a accepted, ptr -> 1
    set_valid(4'b0000);
    check_out("full_1234", 1'b1, 16'h1234, 2'd0);
    rst_in = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 16'h0000, 2'd0);
    rst_in = 1'b0;
    a_in = 16'h1111; b_in = 16'h2222;
    set_valid(4'b0011);
    y_ready_in = 1'b1;
    #1;
    check("post_rst_grant_a", 16'(readys()), 16'b0001);
    tick();
    set_valid(4'b0000);
    check_out("post_rst_word", 1'b1, 16'h1111, 2'd0);
    tick();
    check("drain_after_rst", 16'(y_valid_out), 16'h0);

    // ---- Round robin under full contention ----
    do_reset();
    a_in = 16'hA000; b_in = 16'hB000; c_in = 16'hC000; d_in = 16'hD000;
    set_valid(4'b1111);
    y_ready_in = 1'b1;
    #1;
    check("rr_first_ready", 16'(readys()), 16'b0001);
    tick(); check_out("rr0", 1'b1, 16'hA000, 2'd0);
    check("rr_ready_b", 16'(readys()), 16'b0010);
    tick(); check_out("rr1", 1'b1, 16'hB000, 2'd1);
    tick(); check_out("rr2", 1'b1, 16'hC000, 2'd2);
    check("rr_ready_d", 16'(readys()), 16'b1000);
    tick(); check_out("rr3", 1'b1, 16'hD000, 2'd3);
    tick(); check_out("rr4", 1'b1, 16'hA000, 2'd0);
    set_valid(4'b0000);
    tick();
    check("rr_drain", 16'(y_valid_out), 16'h0);

    // ---- Pointer skip and wrap ----
    do_reset();
    a_in = 16'h00AA; c_in = 16'h00CC;
    set_valid(4'b0101);
    #1;
    check("skip_ptr0_grant_a", 16'(readys()), 16'b0001);
    tick(); check_out("skip_a0", 1'b1, 16'h00AA, 2'd0);   // ptr -> 1
    tick(); check_out("skip_c0", 1'b1, 16'h00CC, 2'd2);   // ptr -> 3
    check("wrap_ptr3_grant_a", 16'(readys()), 16'b0001);
    tick(); check_out("wrap_a", 1'b1, 16'h00AA, 2'd0);    // ptr -> 1
    tick(); check_out("wrap_c", 1'b1, 16'h00CC, 2'd2);    // ptr -> 3
    set_valid(4'b0000);
    tick();
    check("skip_drain", 16'(y_valid_out), 16'h0);

    // ---- Backpressure (ptr = 3) ----
    b_in = 16'h0042;
    set_valid(4'b0010);
    tick(); check_out("bp_load_b", 1'b1, 16'h0042, 2'd1); // ptr -> 2
    y_ready_in = 1'b0;
    d_in = 16'hDDDD;
    set_valid(4'b1000);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_d_ready_low", 16'(d_ready_out), 16'h0);
      tick();
      check_out("bp_hold", 1'b1, 16'h0042, 2'd1);
      d_in = 16'hDDD0 + 16'(i);            // data churn must not leak through
    end
    d_in = 16'hDDDD;
    y_ready_in = 1'b1;
    #1;
    check("bp_release_d_ready", 16'(d_ready_out), 16'h1);
    tick(); check_out("bp_d_word", 1'b1, 16'hDDDD, 2'd3); // ptr -> 0
    set_valid(4'b0000);
    tick();
    check("bp_drain", 16'(y_valid_out), 16'h0);

    // ---- Idle and drain (ptr = 0) ----
    c_in = 16'h7FFF;
    set_valid(4'b0100);
    tick(); check_out("idle_c", 1'b1, 16'h7FFF, 2'd2);    // ptr -> 3
    set_valid(4'b0000);
    tick(); check_out("idle_drained", 1'b0, 16'h7FFF, 2'd2);
    tick(); check_out("idle_still", 1'b0, 16'h7FFF, 2'd2);
    a_in = 16'h0A0A; d_in = 16'h0D0D;
    set_valid(4'b1001);
    #1;
    check("idle_ptr3_grant_d", 16'(readys()), 16'b1000);
    tick(); check_out("idle_d_first", 1'b1, 16'h0D0D, 2'd3);
    check("idle_then_a", 16'(readys()), 16'b0001);
    set_valid(4'b0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux_4x1_rr
